// File: rtl/mux_2x1_sel_arbiter.sv
// Round-robin two-channel arbiter that drives the select line of
// mux_2x1_conditionaloper, with a bounded grant hold time.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req_0      channel 0 request (level)
//   req_1      channel 1 request (level)
//   sel        mux select, 0 = in_0, 1 = in_1 (registered)
//   gnt_0      channel 0 granted (registered)
//   gnt_1      channel 1 granted (registered)
//   out_valid  mux output carries granted data (gnt_0 | gnt_1)
//   hold_cnt   cycles elapsed in the current grant, from 0
module mux_2x1_sel_arbiter #(
   parameter int MAX_HOLD = 4,
   parameter int CNT_W    = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_0,
   input  logic             req_1,
   output logic             sel,
   output logic             gnt_0,
   output logic             gnt_1,
   output logic             out_valid,
   output logic [CNT_W-1:0] hold_cnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_HOLD - 1);

   state_t           state_q, state_d;
   logic             sel_q, sel_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= 1'b0;
         // Pretend channel 1 was served last so channel 0 wins first.
         last_q  <= 1'b1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      last_d  = last_q;
      cnt_d   = '0;
      unique case (state_q)
         IDLE: begin
            if (req_0 && req_1) begin
               // Contention: grant the channel not served last.
               if (last_q) begin
                  state_d = GRANT0;
                  sel_d   = 1'b0;
                  last_d  = 1'b0;
               end else begin
                  state_d = GRANT1;
                  sel_d   = 1'b1;
                  last_d  = 1'b1;
               end
            end else if (req_0) begin
               state_d = GRANT0;
               sel_d   = 1'b0;
               last_d  = 1'b0;
            end else if (req_1) begin
               state_d = GRANT1;
               sel_d   = 1'b1;
               last_d  = 1'b1;
            end
         end
         GRANT0: begin
            if (!req_0 || cnt_q == LAST_CNT) begin
               // Grant ends or hold limit hit: hand over if wanted.
               if (req_1) begin
                  state_d = GRANT1;
                  sel_d   = 1'b1;
                  last_d  = 1'b1;
               end else if (!req_0) begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         GRANT1: begin
            if (!req_1 || cnt_q == LAST_CNT) begin
               if (req_0) begin
                  state_d = GRANT0;
                  sel_d   = 1'b0;
                  last_d  = 1'b0;
               end else if (!req_1) begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output decode, all from registered state
   always_comb begin
      gnt_0     = (state_q == GRANT0);
      gnt_1     = (state_q == GRANT1);
      out_valid = (state_q == GRANT0) || (state_q == GRANT1);
      sel       = sel_q;
      hold_cnt  = cnt_q;
   end

endmodule

// File: tb/tb_mux_2x1_sel_arbiter.sv
// Directed bench for mux_2x1_sel_arbiter with a behavioural
// mux attached (in_0 = 1, in_1 = 0).
module tb_mux_2x1_sel_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_0 = 1'b0;
   logic       req_1 = 1'b0;
   logic       sel;
   logic       gnt_0;
   logic       gnt_1;
   logic       out_valid;
   logic [2:0] hold_cnt;
   logic       mux_outt;

   int checks = 0;
   int errors = 0;

   mux_2x1_sel_arbiter #(
      .MAX_HOLD(4),
      .CNT_W(3)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_0(req_0),
      .req_1(req_1),
      .sel(sel),
      .gnt_0(gnt_0),
      .gnt_1(gnt_1),
      .out_valid(out_valid),
      .hold_cnt(hold_cnt)
   );

   assign mux_outt = sel ? 1'b0 : 1'b1;

   always #5 clk = ~clk;

   // Advance one edge and sample 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Observed bundle: {sel, gnt_0, gnt_1, out_valid, hold_cnt}
   function automatic logic [6:0] obs();
      return {sel, gnt_0, gnt_1, out_valid, hold_cnt};
   endfunction

   task automatic test_reset();
      logic [6:0] exp_v;
      rst_n = 1'b0;
      req_0 = 1'b1;
      req_1 = 1'b1;
      exp_v = 7'b0_0_0_0_000;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (obs() !== exp_v) begin
            errors++;
            $display("FAIL reset edge %0d got %b want %b",
                     i, obs(), exp_v);
         end
      end
   endtask

   task automatic test_single();
      logic [2:0] exp_cnt;
      logic [6:0] exp_v;
      rst_n = 1'b1;
      req_0 = 1'b1;
      req_1 = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         exp_cnt = 3'(k % 4);
         exp_v   = {1'b0, 1'b1, 1'b0, 1'b1, exp_cnt};
         checks++;
         if (obs() !== exp_v || mux_outt !== 1'b1) begin
            errors++;
            $display("FAIL single edge %0d got %b mux %b want %b mux 1",
                     k + 1, obs(), mux_outt, exp_v);
         end
      end
   endtask

   task automatic test_contention();
      logic       g;
      logic [2:0] exp_cnt;
      logic [6:0] exp_v;
      rst_n = 1'b0;
      req_0 = 1'b1;
      req_1 = 1'b1;
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 16; k++) begin
         step();
         g       = ((k / 4) % 2) == 1;
         exp_cnt = 3'(k % 4);
         exp_v   = {g, ~g, g, 1'b1, exp_cnt};
         checks++;
         if (obs() !== exp_v || mux_outt !== ~g) begin
            errors++;
            $display("FAIL contention edge %0d got %b mux %b want %b mux %b",
                     k + 1, obs(), mux_outt, exp_v, ~g);
         end
      end
   endtask

   task automatic test_early_release();
      logic [6:0] exp_v;
      rst_n = 1'b0;
      req_0 = 1'b1;
      req_1 = 1'b1;
      step();
      rst_n = 1'b1;
      step();
      step();
      exp_v = 7'b0_1_0_1_001;
      checks++;
      if (obs() !== exp_v) begin
         errors++;
         $display("FAIL early_pre got %b want %b", obs(), exp_v);
      end
      req_0 = 1'b0;
      step();
      exp_v = 7'b1_0_1_1_000;
      checks++;
      if (obs() !== exp_v) begin
         errors++;
         $display("FAIL early_switch got %b want %b", obs(), exp_v);
      end
   endtask

   task automatic test_idle_hold();
      logic [6:0] exp_v;
      req_0 = 1'b0;
      req_1 = 1'b0;
      step();
      exp_v = 7'b1_0_0_0_000;
      checks++;
      if (obs() !== exp_v) begin
         errors++;
         $display("FAIL idle_hold got %b want %b", obs(), exp_v);
      end
      step();
      checks++;
      if (obs() !== exp_v) begin
         errors++;
         $display("FAIL idle_stay got %b want %b", obs(), exp_v);
      end
      req_0 = 1'b1;
      step();
      exp_v = 7'b0_1_0_1_000;
      checks++;
      if (obs() !== exp_v) begin
         errors++;
         $display("FAIL idle_regrant got %b want %b", obs(), exp_v);
      end
   endtask

   task automatic test_mid_reset();
      logic [6:0] exp_v;
      req_0 = 1'b0;
      req_1 = 1'b1;
      step();
      step();
      step();
      exp_v = 7'b1_0_1_1_010;
      checks++;
      if (obs() !== exp_v) begin
         errors++;
         $display("FAIL mid_pre got %b want %b", obs(), exp_v);
      end
      rst_n = 1'b0;
      req_0 = 1'b1;
      step();
      exp_v = 7'b0_0_0_0_000;
      checks++;
      if (obs() !== exp_v) begin
         errors++;
         $display("FAIL mid_reset got %b want %b", obs(), exp_v);
      end
      rst_n = 1'b1;
      step();
      exp_v = 7'b0_1_0_1_000;
      checks++;
      if (obs() !== exp_v) begin
         errors++;
         $display("FAIL mid_release got %b want %b", obs(), exp_v);
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_single();
      test_contention();
      test_early_release();
      test_idle_hold();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
